// File: rtl/ps2_key_matrix.sv
// PS/2 Set-2 scancode decoder: tracks held state of configurable keys and emits
// single-cycle press/release pulses, with Pause-sequence skipping and timeout recovery.
module ps2_key_matrix #(
  parameter int                    NUM_KEYS       = 4,
  parameter logic [9*NUM_KEYS-1:0] KEY_CODES      = {9'h175, 9'h16B, 9'h172, 9'h174},
  parameter int                    TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                byte_valid,
  input  logic [7:0]          byte_data,
  output logic [NUM_KEYS-1:0] key_down,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [8:0]          last_code,
  output logic                seq_error
);

  localparam int              CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      B_E0     = 8'hE0;
  localparam logic [7:0]      B_F0     = 8'hF0;
  localparam logic [7:0]      B_E1     = 8'hE1;

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, SKIP} state_t;

  state_t           state_reg;
  logic [2:0]       skip_reg;
  logic [CNT_W-1:0] idle_reg;

  logic                make_ev;
  logic                break_ev;
  logic                ext_ev;
  logic                bad_prefix;
  logic                timeout;
  logic                is_prefix;
  logic [8:0]          code_ev;
  logic [NUM_KEYS-1:0] match;

  assign is_prefix = (byte_data == B_E0) || (byte_data == B_F0) || (byte_data == B_E1);
  assign code_ev   = {ext_ev, byte_data};
  // A byte landing on the expiry cycle takes priority over the timeout.
  assign timeout   = !byte_valid && (state_reg != IDLE) && (idle_reg == CNT_LAST);

  // Classify the incoming byte into a completed make/break or a bad prefix.
  always_comb begin
    make_ev    = 1'b0;
    break_ev   = 1'b0;
    ext_ev     = 1'b0;
    bad_prefix = 1'b0;
    if (byte_valid) begin
      case (state_reg)
        IDLE: make_ev = !is_prefix;
        EXT: begin
          ext_ev  = 1'b1;
          make_ev = (byte_data != B_F0) && (byte_data != B_E0);
        end
        BRK: begin
          break_ev   = !is_prefix;
          bad_prefix = is_prefix;
        end
        EXT_BRK: begin
          ext_ev     = 1'b1;
          break_ev   = !is_prefix;
          bad_prefix = is_prefix;
        end
        default: ;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_match
      assign match[gi] = (KEY_CODES[9*gi +: 9] == code_ev);
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      skip_reg  <= 3'd0;
      idle_reg  <= '0;
      last_code <= 9'h000;
      seq_error <= 1'b0;
    end else begin
      seq_error <= bad_prefix || timeout;
      if (make_ev || break_ev)
        last_code <= code_ev;
      if (byte_valid || state_reg == IDLE)
        idle_reg <= '0;
      else
        idle_reg <= idle_reg + 1'b1;

      if (timeout) begin
        state_reg <= IDLE;
      end else if (byte_valid) begin
        case (state_reg)
          IDLE: begin
            if (byte_data == B_E0)
              state_reg <= EXT;
            else if (byte_data == B_F0)
              state_reg <= BRK;
            else if (byte_data == B_E1) begin
              state_reg <= SKIP;
              skip_reg  <= 3'd7;
            end
          end
          EXT: begin
            if (byte_data == B_F0)
              state_reg <= EXT_BRK;
            else if (byte_data != B_E0)
              state_reg <= IDLE;
          end
          SKIP: begin
            skip_reg <= skip_reg - 3'd1;
            if (skip_reg == 3'd1)
              state_reg <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  // Duplicate codes simply match several slots, so all of them update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_down    <= '0;
      key_press   <= '0;
      key_release <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        key_press[i]   <= make_ev && match[i] && !key_down[i];
        key_release[i] <= break_ev && match[i] && key_down[i];
        if (make_ev && match[i])
          key_down[i] <= 1'b1;
        else if (break_ev && match[i])
          key_down[i] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_matrix.sv
// Bench for ps2_key_matrix: directed scenarios plus random byte streams checked
// against a prefix-flag reference model of the scancode protocol.
module tb_ps2_key_matrix;

  localparam int          T      = 16;
  localparam logic [35:0] CODES0 = {9'h074, 9'h072, 9'h06B, 9'h075};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;

  logic [3:0] kd0, kp0, kr0;
  logic [8:0] lc0;
  logic       se0;
  logic [0:0] kd1, kp1, kr1;
  logic [8:0] lc1;
  logic       se1;

  always #5 clk = ~clk;

  ps2_key_matrix #(.NUM_KEYS(4), .KEY_CODES(CODES0), .TIMEOUT_CYCLES(T)) dut0 (
    .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .key_down(kd0), .key_press(kp0), .key_release(kr0), .last_code(lc0), .seq_error(se0));

  ps2_key_matrix #(.NUM_KEYS(1), .KEY_CODES(9'h175), .TIMEOUT_CYCLES(T)) dut1 (
    .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .key_down(kd1), .key_press(kp1), .key_release(kr1), .last_code(lc1), .seq_error(se1));

  int total = 0;
  int bad   = 0;

  bit [8:0] codes0 [4] = '{9'h075, 9'h06B, 9'h072, 9'h074};
  bit [8:0] code1      = 9'h175;

  bit [3:0] m_kd0, m_kp0, m_kr0;
  bit       m_kd1, m_kp1, m_kr1;
  bit [8:0] m_lc;
  bit       m_se;
  bit       pfx_ext, pfx_brk;
  int       skip_left, idle_run;

  function automatic void model_reset();
    m_kd0 = 0; m_kp0 = 0; m_kr0 = 0;
    m_kd1 = 0; m_kp1 = 0; m_kr1 = 0;
    m_lc = 9'h000; m_se = 0;
    pfx_ext = 0; pfx_brk = 0; skip_left = 0; idle_run = 0;
  endfunction

  function automatic void model_step(bit v, bit [7:0] b);
    bit       have_ev = 0;
    bit       is_brk = 0;
    bit [8:0] code = 9'h000;
    bit       pending = pfx_ext || pfx_brk || (skip_left > 0);
    m_kp0 = 0; m_kr0 = 0; m_kp1 = 0; m_kr1 = 0; m_se = 0;
    if (v) begin
      idle_run = 0;
      if (skip_left > 0) skip_left--;
      else if (pfx_brk && (b == 8'hE0 || b == 8'hF0 || b == 8'hE1)) begin
        m_se = 1; pfx_ext = 0; pfx_brk = 0;
      end
      else if (b == 8'hE0) pfx_ext = 1;
      else if (b == 8'hF0) pfx_brk = 1;
      else if (b == 8'hE1 && !pfx_ext) skip_left = 7;
      else begin
        have_ev = 1; is_brk = pfx_brk; code = {pfx_ext, b};
        pfx_ext = 0; pfx_brk = 0;
      end
    end else if (pending) begin
      idle_run++;
      if (idle_run == T) begin
        m_se = 1; pfx_ext = 0; pfx_brk = 0; skip_left = 0; idle_run = 0;
      end
    end else begin
      idle_run = 0;
    end
    if (have_ev) begin
      m_lc = code;
      for (int i = 0; i < 4; i++) begin
        if (codes0[i] == code) begin
          if (!is_brk && !m_kd0[i]) begin m_kd0[i] = 1; m_kp0[i] = 1; end
          if (is_brk && m_kd0[i])   begin m_kd0[i] = 0; m_kr0[i] = 1; end
        end
      end
      if (code1 == code) begin
        if (!is_brk && !m_kd1) begin m_kd1 = 1; m_kp1 = 1; end
        if (is_brk && m_kd1)   begin m_kd1 = 0; m_kr1 = 1; end
      end
    end
  endfunction

  function automatic logic [34:0] obs();
    return {kd0, kp0, kr0, lc0, se0, kd1, kp1, kr1, lc1, se1};
  endfunction

  function automatic logic [34:0] expv();
    return {m_kd0, m_kp0, m_kr0, m_lc, m_se, m_kd1, m_kp1, m_kr1, m_lc, m_se};
  endfunction

  function automatic bit [7:0] pick_byte();
    case ($urandom_range(0, 19))
      0, 1:    return 8'hE0;
      2, 3, 4: return 8'hF0;
      5:       return 8'hE1;
      6, 7:    return 8'h75;
      8, 9:    return 8'h6B;
      10, 11:  return 8'h72;
      12, 13:  return 8'h74;
      14:      return 8'h12;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic cycle(input bit v, input bit [7:0] b);
    @(negedge clk);
    byte_valid = v;
    byte_data  = b;
    model_step(v, b);
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = 8'h75;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    total++;
    if (obs() !== 35'd0)
      $display("FAIL reset_state: got %h want 0", obs());
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_make_break();
    cycle(1, 8'h75);
    total++;
    if (kd0[0] !== 1'b1 || kp0[0] !== 1'b1 || lc0 !== 9'h075) begin
      bad++; $display("FAIL make_up: got kd=%b kp=%b lc=%h want kd=1 kp=1 lc=075", kd0[0], kp0[0], lc0);
    end
    cycle(0, 8'h00);
    total++;
    if (kp0[0] !== 1'b0 || kd0[0] !== 1'b1) begin
      bad++; $display("FAIL press_width: got kd=%b kp=%b want kd=1 kp=0", kd0[0], kp0[0]);
    end
    cycle(1, 8'hF0);
    cycle(1, 8'h75);
    total++;
    if (kr0[0] !== 1'b1 || kd0[0] !== 1'b0 || lc0 !== 9'h075) begin
      bad++; $display("FAIL break_up: got kd=%b kr=%b lc=%h want kd=0 kr=1 lc=075", kd0[0], kr0[0], lc0);
    end
    cycle(0, 8'h00);
    total++;
    if (kr0[0] !== 1'b0) begin
      bad++; $display("FAIL release_width: got kr=%b want 0", kr0[0]);
    end
    total++;
    if (obs() !== expv()) begin
      bad++; $display("FAIL make_break_model: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_extended();
    cycle(1, 8'hE0);
    cycle(1, 8'h75);
    total++;
    if (kd1 !== 1'b1 || kp1 !== 1'b1 || lc1 !== 9'h175 || kd0[0] !== 1'b0) begin
      bad++; $display("FAIL ext_make: got kd1=%b kp1=%b lc=%h kd0=%b want 1 1 175 0", kd1, kp1, lc1, kd0[0]);
    end
    cycle(1, 8'h75);
    total++;
    if (kd1 !== 1'b1 || kp1 !== 1'b0 || kr1 !== 1'b0 || lc1 !== 9'h075) begin
      bad++; $display("FAIL ext_plain: got kd1=%b kp1=%b kr1=%b lc=%h want 1 0 0 075", kd1, kp1, kr1, lc1);
    end
    cycle(1, 8'hE0);
    cycle(1, 8'hF0);
    cycle(1, 8'h75);
    total++;
    if (kr1 !== 1'b1 || kd1 !== 1'b0 || lc1 !== 9'h175) begin
      bad++; $display("FAIL ext_break: got kr1=%b kd1=%b lc=%h want 1 0 175", kr1, kd1, lc1);
    end
    cycle(1, 8'hF0);
    cycle(1, 8'h75);
    total++;
    if (obs() !== expv()) begin
      bad++; $display("FAIL ext_model: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_typematic();
    int presses = 0;
    int rels = 0;
    repeat (3) begin
      cycle(1, 8'h6B);
      presses += int'(kp0[1]);
    end
    cycle(0, 8'h00);
    presses += int'(kp0[1]);
    total++;
    if (presses != 1 || kd0[1] !== 1'b1) begin
      bad++; $display("FAIL typematic: got presses=%0d kd=%b want 1 1", presses, kd0[1]);
    end
    cycle(1, 8'hF0);
    cycle(1, 8'h6B);
    rels += int'(kr0[1]);
    cycle(1, 8'hF0);
    cycle(1, 8'h6B);
    rels += int'(kr0[1]);
    total++;
    if (rels != 1 || kd0[1] !== 1'b0) begin
      bad++; $display("FAIL typematic_release: got releases=%0d kd=%b want 1 0", rels, kd0[1]);
    end
  endtask

  task automatic test_pause();
    bit [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    logic [8:0] lc_before = lc0;
    int events = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1, seq[i]);
      if (|{kp0, kr0, kp1, kr1, se0}) events++;
    end
    total++;
    if (events != 0 || lc0 !== lc_before) begin
      bad++; $display("FAIL pause_quiet: got events=%0d lc=%h want 0 %h", events, lc0, lc_before);
    end
    cycle(1, 8'h72);
    total++;
    if (kp0[2] !== 1'b1 || lc0 !== 9'h072) begin
      bad++; $display("FAIL pause_after: got kp2=%b lc=%h want 1 072", kp0[2], lc0);
    end
    cycle(1, 8'hF0);
    cycle(1, 8'h72);
  endtask

  task automatic test_timeout();
    cycle(1, 8'hF0);
    for (int i = 1; i <= T; i++) begin
      cycle(0, 8'h00);
      if (i == T - 1) begin
        total++;
        if (se0 !== 1'b0) begin
          bad++; $display("FAIL timeout_early: got se=%b want 0 at idle %0d", se0, i);
        end
      end
    end
    total++;
    if (se0 !== 1'b1) begin
      bad++; $display("FAIL timeout_fire: got se=%b want 1", se0);
    end
    cycle(0, 8'h00);
    total++;
    if (se0 !== 1'b0) begin
      bad++; $display("FAIL timeout_width: got se=%b want 0", se0);
    end
    cycle(1, 8'h74);
    total++;
    if (kp0[3] !== 1'b1 || kd0[3] !== 1'b1) begin
      bad++; $display("FAIL timeout_recover: got kp3=%b kd3=%b want 1 1", kp0[3], kd0[3]);
    end
    cycle(1, 8'hF0);
    repeat (T - 1) cycle(0, 8'h00);
    cycle(1, 8'h74);
    total++;
    if (se0 !== 1'b0 || kr0[3] !== 1'b1 || kd0[3] !== 1'b0) begin
      bad++; $display("FAIL timeout_race: got se=%b kr3=%b kd3=%b want 0 1 0", se0, kr0[3], kd0[3]);
    end
    cycle(0, 8'h00);
    total++;
    if (se0 !== 1'b0) begin
      bad++; $display("FAIL timeout_race_after: got se=%b want 0", se0);
    end
  endtask

  task automatic test_bad_prefix();
    cycle(1, 8'hF0);
    cycle(1, 8'hE0);
    total++;
    if (se0 !== 1'b1) begin
      bad++; $display("FAIL bad_prefix: got se=%b want 1", se0);
    end
    cycle(1, 8'h75);
    total++;
    if (kp0[0] !== 1'b1 || se0 !== 1'b0) begin
      bad++; $display("FAIL bad_prefix_recover: got kp0=%b se=%b want 1 0", kp0[0], se0);
    end
    cycle(1, 8'hF0);
    cycle(1, 8'h75);
  endtask

  task automatic test_back_to_back();
    int errs = 0;
    for (int n = 0; n < 300; n++) begin
      cycle(1, pick_byte());
      total++;
      if (obs() !== expv()) begin
        bad++; errs++;
        if (errs <= 5) $display("FAIL back_to_back[%0d]: got %h want %h", n, obs(), expv());
      end
    end
  endtask

  task automatic test_random();
    int errs = 0;
    for (int n = 0; n < 2000; n++) begin
      bit v = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 49) == 0) begin
        int gap = $urandom_range(T - 2, T + 3);
        for (int g = 0; g < gap; g++) begin
          cycle(0, 8'h00);
          total++;
          if (obs() !== expv()) begin
            bad++; errs++;
            if (errs <= 5) $display("FAIL random_gap[%0d]: got %h want %h", n, obs(), expv());
          end
        end
      end
      cycle(v, v ? pick_byte() : 8'h00);
      total++;
      if (obs() !== expv()) begin
        bad++; errs++;
        if (errs <= 5) $display("FAIL random[%0d]: got %h want %h", n, obs(), expv());
      end
    end
  endtask

  task automatic test_async_reset();
    cycle(1, 8'hF0); cycle(1, 8'hF0); cycle(0, 8'h00); cycle(0, 8'h00);
    repeat (T + 1) cycle(0, 8'h00);
    cycle(1, 8'h75); cycle(1, 8'h6B); cycle(1, 8'h72); cycle(1, 8'h74);
    cycle(1, 8'hE0); cycle(1, 8'h75);
    cycle(1, 8'hE0); cycle(1, 8'hF0);
    total++;
    if (kd0 !== 4'b1111 || kd1 !== 1'b1) begin
      bad++; $display("FAIL async_setup: got kd0=%b kd1=%b want 1111 1", kd0, kd1);
    end
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    total++;
    if (obs() !== 35'd0) begin
      bad++; $display("FAIL async_reset: got %h want 0", obs());
    end
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = 8'h75;
    @(posedge clk);
    #1;
    total++;
    if (obs() !== 35'd0) begin
      bad++; $display("FAIL reset_ignores_byte: got %h want 0", obs());
    end
    @(negedge clk);
    byte_valid = 1'b0;
    reset = 1'b0;
    cycle(1, 8'h75);
    total++;
    if (kp0 !== 4'b0001 || kd0 !== 4'b0001 || se0 !== 1'b0) begin
      bad++; $display("FAIL after_reset: got kp0=%b kd0=%b se=%b want 0001 0001 0", kp0, kd0, se0);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    if (bad == 0 && total == 1 && obs() !== 35'd0) bad++;
    test_make_break();
    test_extended();
    test_typematic();
    test_pause();
    test_timeout();
    test_bad_prefix();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
